// File: rtl/dwrr_pkg.sv
// Shared types, defaults and saturating arithmetic for the DWRR credit path.
package dwrr_pkg;

   localparam int DEF_FLOW_W       = 3;
   localparam int DEF_MAX_CREDIT_W = 3;
   localparam int CREDIT_MAX       = (1 << DEF_MAX_CREDIT_W) - 1;

   typedef logic [DEF_FLOW_W-1:0]       flow_t;
   typedef logic [DEF_MAX_CREDIT_W-1:0] credit_t;

   // base + inc - dec, clamped to max; operands are zero-extended so the
   // intermediate never wraps for any legal credit width.
   function automatic logic [15:0] sat_add(input logic [15:0] base,
                                           input logic [15:0] inc,
                                           input logic        dec,
                                           input logic [15:0] max);
      logic [15:0] s;
      s = base + inc - {15'd0, dec};
      return (s > max) ? max : s;
   endfunction

endpackage

// File: rtl/dwrr_req_delay.sv
// Valid-bit delay line matching the credit-order table read latency.
module dwrr_req_delay #(
   parameter int STAGES = 3
) (
   input  logic clk,
   input  logic rstn,
   input  logic din,
   output logic dout
);

   logic [STAGES:0] vld_pipe;

   assign vld_pipe[0] = din;
   assign dout        = vld_pipe[STAGES];

   always_ff @(posedge clk) begin
      if (!rstn) vld_pipe[STAGES:1] <= '0;
      else       vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
   end

endmodule

// File: rtl/dwrr_credit_ctrl.sv
// Per-flow credit counters: replenish on credit-order table return, debit on
// grant, registered lookup, and single-cycle error pulses.
module dwrr_credit_ctrl
   import dwrr_pkg::*;
#(
   parameter int FLOW_W       = DEF_FLOW_W,
   parameter int MAX_CREDIT_W = DEF_MAX_CREDIT_W,
   parameter int QUANTUM      = 1,
   parameter int ORDER_LAT    = 3
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    order_init_done,
   output logic                    order_rd_req,
   input  logic [FLOW_W-1:0]       order_rd_flow,
   input  logic                    packet_tlast,
   input  logic [FLOW_W-1:0]       flow_check,
   output logic [MAX_CREDIT_W-1:0] flow_credit_value,
   input  logic                    consume_credit_valid,
   input  logic [FLOW_W-1:0]       consume_credit_flow,
   output logic                    ready,
   output logic                    credit_underflow,
   output logic                    tlast_dropped
);

   localparam int          NUM_FLOWS = 1 << FLOW_W;
   localparam logic [15:0] CMAX      = 16'((1 << MAX_CREDIT_W) - 1);

   logic [NUM_FLOWS-1:0][MAX_CREDIT_W-1:0] credit, credit_nxt;
   logic                                   rep_vld;

   dwrr_req_delay #(.STAGES(ORDER_LAT)) u_req_delay (
      .clk  (clk),
      .rstn (rstn),
      .din  (order_rd_req),
      .dout (rep_vld)
   );

   for (genvar i = 0; i < NUM_FLOWS; i++) begin : g_flow
      logic        rep, deb;
      logic [15:0] nxt;

      assign rep = rep_vld && (order_rd_flow == FLOW_W'(i));
      assign deb = consume_credit_valid && (consume_credit_flow == FLOW_W'(i));

      // A same-cycle debit folds into the replenish sum before saturation.
      always_comb begin
         nxt = 16'(credit[i]);
         if (rep)
            nxt = sat_add(16'(credit[i]), 16'(QUANTUM), deb, CMAX);
         else if (deb && credit[i] != '0)
            nxt = 16'(credit[i]) - 16'd1;
      end

      assign credit_nxt[i] = nxt[MAX_CREDIT_W-1:0];
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         credit            <= '0;
         ready             <= 1'b0;
         order_rd_req      <= 1'b0;
         tlast_dropped     <= 1'b0;
         credit_underflow  <= 1'b0;
         flow_credit_value <= '0;
      end else begin
         credit            <= credit_nxt;
         ready             <= order_init_done;
         order_rd_req      <= packet_tlast & ready;
         tlast_dropped     <= packet_tlast & ~ready;
         flow_credit_value <= credit[flow_check];
         credit_underflow  <= consume_credit_valid
                              && (credit[consume_credit_flow] == '0)
                              && !(rep_vld && (order_rd_flow == consume_credit_flow));
      end
   end

endmodule
